// File: rtl/tank_pkg.sv
// tank_pkg: direction codes and launcher state type shared across the tank logic.
package tank_pkg;
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        LN_IDLE,
        LN_LAUNCH,
        LN_FLYING,
        LN_COOLDOWN
    } launcher_state_e;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-FF synchroniser with a one-cycle pulse on the synchronised rising edge.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise
);
    logic r_s1, r_s2, r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= i_d;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_prev;
endmodule

// File: rtl/shell_launcher.sv
// shell_launcher: tank-side initiator of the shell launch handshake with
// ammo, reload, ack-timeout and cooldown rules.
module shell_launcher
    import tank_pkg::*;
#(
    parameter int MAX_AMMO       = 3,
    parameter int RELOAD_TICKS   = 16,
    parameter int COOLDOWN_TICKS = 4,
    parameter int ACK_TIMEOUT    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clk_8Hz,
    input  logic       fire_btn,
    input  logic [1:0] tank_dir,
    input  logic       shell_state_feedback,
    input  logic       shell_hit,
    output logic       shell_state,
    output logic [1:0] shell_dir,
    output logic [2:0] ammo_count,
    output logic       fire_ack,
    output logic       busy
);
    localparam int RW = $clog2(RELOAD_TICKS) + 1;
    localparam int TW = $clog2(ACK_TIMEOUT) + 1;
    localparam int CW = $clog2(COOLDOWN_TICKS) + 1;

    logic w_tick, w_press, w_not_full, w_rl_done, w_fire;

    launcher_state_e r_state;
    logic [RW-1:0]   r_rl_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic [CW-1:0]   r_cd_cnt;
    logic            r_shell_state, r_fire_ack;
    logic [1:0]      r_shell_dir;
    logic [2:0]      r_ammo;

    sync_edge u_tick (.clk(clk), .rst_n(rst_n), .i_d(clk_8Hz),  .o_rise(w_tick));
    sync_edge u_fire (.clk(clk), .rst_n(rst_n), .i_d(fire_btn), .o_rise(w_press));

    assign w_not_full = r_ammo < 3'(MAX_AMMO);
    assign w_rl_done  = enable && w_tick && w_not_full && (r_rl_cnt == RW'(RELOAD_TICKS - 1));
    // acceptance looks at the pre-update ammo, so a coincident reload cannot rescue an empty magazine
    assign w_fire     = enable && (r_state == LN_IDLE) && w_press && (r_ammo != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= LN_IDLE;
            r_rl_cnt      <= '0;
            r_to_cnt      <= '0;
            r_cd_cnt      <= '0;
            r_shell_state <= 1'b0;
            r_shell_dir   <= DIR_UP;
            r_ammo        <= 3'(MAX_AMMO);
            r_fire_ack    <= 1'b0;
        end else begin
            r_fire_ack <= w_fire;
            if (!w_not_full)
                r_rl_cnt <= '0;
            else if (enable && w_tick)
                r_rl_cnt <= w_rl_done ? '0 : r_rl_cnt + RW'(1);
            if (w_fire && !w_rl_done)
                r_ammo <= r_ammo - 3'd1;
            else if (!w_fire && w_rl_done)
                r_ammo <= r_ammo + 3'd1;
            if (!enable) begin
                r_state       <= LN_IDLE;
                r_shell_state <= 1'b0;
                r_to_cnt      <= '0;
                r_cd_cnt      <= '0;
            end else begin
                case (r_state)
                    LN_IDLE: if (w_fire) begin
                        r_shell_dir   <= tank_dir;
                        r_shell_state <= 1'b1;
                        r_to_cnt      <= '0;
                        r_state       <= LN_LAUNCH;
                    end
                    LN_LAUNCH: if (shell_state_feedback) begin
                        r_to_cnt <= '0;
                        r_state  <= LN_FLYING;
                    end else if (w_tick) begin
                        // no feedback in time: shell was never spawned, the round stays spent
                        if (r_to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                            r_shell_state <= 1'b0;
                            r_to_cnt      <= '0;
                            r_cd_cnt      <= '0;
                            r_state       <= LN_COOLDOWN;
                        end else begin
                            r_to_cnt <= r_to_cnt + TW'(1);
                        end
                    end
                    LN_FLYING: if (!shell_state_feedback || shell_hit) begin
                        r_shell_state <= 1'b0;
                        r_to_cnt      <= '0;
                        r_cd_cnt      <= '0;
                        r_state       <= LN_COOLDOWN;
                    end
                    LN_COOLDOWN: if (w_tick) begin
                        if (r_cd_cnt == CW'(COOLDOWN_TICKS - 1)) begin
                            r_cd_cnt <= '0;
                            r_state  <= LN_IDLE;
                        end else begin
                            r_cd_cnt <= r_cd_cnt + CW'(1);
                        end
                    end
                    default: r_state <= LN_IDLE;
                endcase
            end
        end
    end

    assign shell_state = r_shell_state;
    assign shell_dir   = r_shell_dir;
    assign ammo_count  = r_ammo;
    assign fire_ack    = r_fire_ack;
    assign busy        = (r_state != LN_IDLE);
endmodule

// File: tb/tb_shell_launcher.sv
// tb_shell_launcher: directed test-plan scenarios plus randomized flights checked
// against a transaction-level magazine/flight model.
module tb_shell_launcher;
    import tank_pkg::*;

    localparam int MAX = 3;
    localparam int RL  = 16;
    localparam int CD  = 4;
    localparam int TO  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       clk_8Hz = 1'b0;
    logic       fire_btn = 1'b0;
    logic [1:0] tank_dir = 2'b00;
    logic       shell_state_feedback = 1'b0;
    logic       shell_hit = 1'b0;
    logic       shell_state;
    logic [1:0] shell_dir;
    logic [2:0] ammo_count;
    logic       fire_ack;
    logic       busy;

    int   n_checks = 0;
    int   n_pass = 0;
    int   m_ammo = MAX;
    int   m_rl = 0;
    logic [1:0] m_dir = 2'b00;
    bit   last_acc;

    shell_launcher #(
        .MAX_AMMO(MAX), .RELOAD_TICKS(RL), .COOLDOWN_TICKS(CD), .ACK_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clk_8Hz(clk_8Hz),
        .fire_btn(fire_btn), .tank_dir(tank_dir),
        .shell_state_feedback(shell_state_feedback), .shell_hit(shell_hit),
        .shell_state(shell_state), .shell_dir(shell_dir), .ammo_count(ammo_count),
        .fire_ack(fire_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one game tick: a round is regained every RL ticks while not full and enabled
    function automatic void model_tick();
        if (enable && m_ammo < MAX) begin
            m_rl++;
            if (m_rl == RL) begin
                m_rl = 0;
                m_ammo++;
            end
        end
    endfunction

    // optional tick and/or press landing on the same cycle; idle says the launcher is ready
    task automatic act(input bit t, input bit p, input bit idle);
        bit acc;
        acc = p && idle && enable && (m_ammo > 0);
        if (t) clk_8Hz = 1'b1;
        if (p) fire_btn = 1'b1;
        step(3);
        if (t) model_tick();
        if (acc) begin
            m_ammo--;
            m_dir = tank_dir;
        end
        if (p) begin
            check("fire_ack", 32'(fire_ack), 32'(acc));
            check("ammo_after_press", 32'(ammo_count), 32'(m_ammo));
            if (acc) begin
                check("shell_state_on_fire", 32'(shell_state), 32'd1);
                check("shell_dir_latched", 32'(shell_dir), 32'(m_dir));
            end
        end
        clk_8Hz = 1'b0;
        fire_btn = 1'b0;
        step(1);
        if (p) check("fire_ack_one_cycle", 32'(fire_ack), 32'd0);
        step(2);
        last_acc = acc;
    endtask

    // kind: 0 normal end, 1 ack timeout, 2 hit
    task automatic fly(input int r1, input int r2, input int kind);
        check("busy_in_flight", 32'(busy), 32'd1);
        if (kind == 1) begin
            for (int i = 0; i < TO; i++) begin
                act(1'b1, 1'b0, 1'b0);
                check("ss_timeout", 32'(shell_state), 32'(i < TO - 1));
            end
        end else begin
            repeat (r1) act(1'b1, 1'b0, 1'b0);
            shell_state_feedback = 1'b1;
            step(1);
            repeat (r2) act(1'b1, 1'b0, 1'b0);
            check("ss_flying", 32'(shell_state), 32'd1);
            check("dir_stable", 32'(shell_dir), 32'(m_dir));
            if (kind == 2) begin
                shell_hit = 1'b1;
                step(1);
                shell_hit = 1'b0;
            end else begin
                shell_state_feedback = 1'b0;
                step(1);
            end
            check("ss_end", 32'(shell_state), 32'd0);
            shell_state_feedback = 1'b0;
        end
        check("ammo_after_flight", 32'(ammo_count), 32'(m_ammo));
        for (int i = 0; i < CD; i++) begin
            check("busy_cooldown", 32'(busy), 32'd1);
            act(1'b1, 1'b1, 1'b0);
        end
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fire_btn = 1'b0;
        clk_8Hz = 1'b0;
        shell_state_feedback = 1'b0;
        shell_hit = 1'b0;
        m_ammo = MAX;
        m_rl = 0;
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        do_reset();
        check("rst_shell_state", 32'(shell_state), 32'd0);
        check("rst_shell_dir", 32'(shell_dir), 32'd0);
        check("rst_fire_ack", 32'(fire_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ammo", 32'(ammo_count), 32'(MAX));

        // fire right, turn the tank, fly 2+10 ticks, presses in cooldown ignored
        tank_dir = DIR_RIGHT;
        act(1'b0, 1'b1, 1'b1);
        check("first_ammo", 32'(ammo_count), 32'd2);
        tank_dir = DIR_UP;
        fly(2, 10, 0);
        act(1'b0, 1'b1, 1'b1);
        check("fire_after_cooldown", 32'(last_acc), 32'd1);
        fly(0, 0, 1);
        act(1'b0, 1'b1, 1'b1);
        fly(1, 2, 2);

        // drain the magazine, then reload while a press lands on the reload tick
        do_reset();
        for (int i = 0; i < MAX; i++) begin
            tank_dir = 2'($urandom_range(0, 3));
            act(1'b0, 1'b1, 1'b1);
            fly(0, 0, 0);
        end
        check("empty", 32'(ammo_count), 32'd0);
        act(1'b0, 1'b1, 1'b1);
        check("empty_reject_ss", 32'(shell_state), 32'd0);
        while (m_rl < RL - 1) act(1'b1, 1'b0, 1'b1);
        act(1'b1, 1'b1, 1'b1);
        check("reload_coincident_reject", 32'(last_acc), 32'd0);
        check("reload_one", 32'(ammo_count), 32'd1);
        act(1'b0, 1'b1, 1'b1);
        fly(0, 0, 1);

        // asynchronous reset mid-flight
        do_reset();
        act(1'b0, 1'b1, 1'b1);
        shell_state_feedback = 1'b1;
        step(2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ss", 32'(shell_state), 32'd0);
        check("rst_mid_ammo", 32'(ammo_count), 32'(MAX));
        check("rst_mid_busy", 32'(busy), 32'd0);
        do_reset();

        // enable drop mid-flight: ammo and reload held, presses ignored
        act(1'b0, 1'b1, 1'b1);
        shell_state_feedback = 1'b1;
        step(2);
        enable = 1'b0;
        step(1);
        check("dis_ss", 32'(shell_state), 32'd0);
        check("dis_busy", 32'(busy), 32'd0);
        check("dis_ammo", 32'(ammo_count), 32'(m_ammo));
        shell_state_feedback = 1'b0;
        repeat (3) act(1'b1, 1'b1, 1'b0);
        check("dis_ammo_held", 32'(ammo_count), 32'(m_ammo));
        enable = 1'b1;
        step(1);
        act(1'b0, 1'b1, 1'b1);
        fly(1, 3, 0);

        // randomized flights against the transaction model
        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 6)) act(1'b1, 1'b0, 1'b1);
            tank_dir = 2'($urandom_range(0, 3));
            act(($urandom_range(0, 2) == 0), 1'b1, 1'b1);
            if (last_acc) begin
                tank_dir = 2'($urandom_range(0, 3));
                fly($urandom_range(0, 3), $urandom_range(0, 8), $urandom_range(0, 2));
            end
            check("rand_ammo", 32'(ammo_count), 32'(m_ammo));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
